// File: rtl/cons_pkg.sv
// Shared types and constants for the console examine/deposit DMA engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cons_pkg;

  // Engine sequencer states
  typedef enum logic [2:0] {
    CS_IDLE,
    CS_LOAD,
    CS_START,
    CS_REQ,
    CS_XFER,
    CS_DONE
  } cs_state_t;

  // Index of each panel key in the pending-flag vector
  localparam int KEY_LOAD  = 0;
  localparam int KEY_START = 1;
  localparam int KEY_EXAM  = 2;
  localparam int KEY_DEP   = 3;
  localparam int KEY_NUM   = 4;

  // Console switch register address on the system bus
  localparam logic [15:0] SWR_ADR = 16'o177570;

  // Byte lane select for a byte access: even address -> low lane
  function automatic logic [1:0] byte_sel(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Panel key synchroniser, release detector and one-deep pending flag.
// Latency: flag sets 3 clocks after the key is released.
// Backpressure: releases seen while i_accept=0 are dropped, never queued.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_cpu_run,
  input  logic i_accept,
  input  logic i_consume,
  output logic o_pend
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_pend;
  logic w_rel;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_key;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // A key acts on release, and only while the CPU is halted
  assign w_rel = r_prev & ~r_s2 & ~i_cpu_run;

  // Pending flag: a clear (consume or CPU running) beats a new release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else if (i_cpu_run || i_consume) begin
      r_pend <= 1'b0;
    end else if (w_rel && i_accept) begin
      r_pend <= 1'b1;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/cons_dma_engine.sv
// Front-panel load/start/examine/deposit engine driving a DMA master port.
// Latency: key acts 4 clocks after release; an access is req, gnt, stb..ack, then gnt release.
// Backpressure: waits on dma_gnt and dma_ack_i; an ack missing for TMO cycles aborts with addr_err.
module cons_dma_engine
  import cons_pkg::*;
#(
  parameter int          AW      = 22,
  parameter int          DW      = 16,
  parameter int          TMO     = 255,
  parameter logic [15:0] RST_ADR = 16'o165020
) (
  input  logic          clk_p,
  input  logic          sys_init_n,
  input  logic          cpu_run,
  input  logic          key_load,
  input  logic          key_exam,
  input  logic          key_dep,
  input  logic          key_start,
  input  logic          byte_mode,
  input  logic [AW-1:0] switch_sr,
  output logic          dma_req,
  input  logic          dma_gnt,
  output logic [AW-1:0] dma_adr_o,
  output logic [DW-1:0] dma_dat_o,
  input  logic [DW-1:0] dma_dat_i,
  output logic          dma_stb_o,
  output logic          dma_we_o,
  output logic [1:0]    dma_sel_o,
  input  logic          dma_ack_i,
  output logic [AW-1:0] address_reg,
  output logic          address_act,
  output logic [DW-1:0] data_reg,
  output logic          addr_err,
  output logic [15:0]   startup_adr,
  output logic          cons_start
);

  localparam int          HW       = DW / 2;
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  cs_state_t         r_state;
  cs_state_t         w_state_nxt;
  logic [KEY_NUM-1:0] w_key_raw;
  logic [KEY_NUM-1:0] w_pend;
  logic [KEY_NUM-1:0] w_consume;
  logic              w_idle;

  logic              r_req;
  logic              r_stb;
  logic              r_we;
  logic [1:0]        r_sel;
  logic [AW-1:0]     r_adr_o;
  logic [DW-1:0]     r_dat_o;
  logic [AW-1:0]     r_address;
  logic              r_act;
  logic [DW-1:0]     r_data;
  logic              r_err;
  logic [15:0]       r_startup;
  logic [1:0]        r_start_cnt;
  logic              r_byte;
  logic              r_op_dep;
  logic              r_exam_last;
  logic              r_dep_last;
  logic [15:0]       r_tmo;

  logic              w_same_op;
  logic [AW-1:0]     w_inc_adr;
  logic [AW-1:0]     w_xfer_adr;
  logic [HW-1:0]     w_rd_lane;

  assign w_key_raw[KEY_LOAD]  = key_load;
  assign w_key_raw[KEY_START] = key_start;
  assign w_key_raw[KEY_EXAM]  = key_exam;
  assign w_key_raw[KEY_DEP]   = key_dep;
  assign w_idle               = (r_state == CS_IDLE);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_sync_edge u_key (
      .clk       (clk_p),
      .rst_n     (sys_init_n),
      .i_key     (w_key_raw[g]),
      .i_cpu_run (cpu_run),
      .i_accept  (w_idle),
      .i_consume (w_consume[g]),
      .o_pend    (w_pend[g])
    );
  end

  // Repeating the same operation steps the address; switching operations does not
  assign w_same_op  = r_op_dep ? r_dep_last : r_exam_last;
  assign w_inc_adr  = r_address + (r_byte ? AW'(1) : AW'(2));
  assign w_xfer_adr = w_same_op ? w_inc_adr : r_address;
  assign w_rd_lane  = r_address[0] ? dma_dat_i[DW-1:HW] : dma_dat_i[HW-1:0];

  // State register
  always_ff @(posedge clk_p or negedge sys_init_n) begin
    if (!sys_init_n) begin
      r_state <= CS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and key arbitration (load > start > exam > dep)
  always_comb begin
    w_state_nxt = r_state;
    w_consume   = '0;
    case (r_state)
      CS_IDLE: begin
        if (!cpu_run) begin
          if (w_pend[KEY_LOAD]) begin
            w_consume[KEY_LOAD] = 1'b1;
            w_state_nxt         = CS_LOAD;
          end else if (w_pend[KEY_START]) begin
            w_consume[KEY_START] = 1'b1;
            w_state_nxt          = CS_START;
          end else if (w_pend[KEY_EXAM]) begin
            w_consume[KEY_EXAM] = 1'b1;
            w_state_nxt         = CS_REQ;
          end else if (w_pend[KEY_DEP]) begin
            w_consume[KEY_DEP] = 1'b1;
            w_state_nxt        = CS_REQ;
          end
        end
      end
      CS_LOAD:  w_state_nxt = CS_IDLE;
      CS_START: w_state_nxt = CS_IDLE;
      CS_REQ: begin
        if (cpu_run) begin
          w_state_nxt = CS_IDLE;
        end else if (dma_gnt) begin
          w_state_nxt = CS_XFER;
        end
      end
      CS_XFER: begin
        if (dma_ack_i || (r_tmo == TMO_LAST)) begin
          w_state_nxt = CS_DONE;
        end
      end
      CS_DONE: begin
        if (!dma_gnt) begin
          w_state_nxt = CS_IDLE;
        end
      end
      default: w_state_nxt = CS_IDLE;
    endcase
  end

  // Datapath: panel registers, bus cycle drive, ack/timeout handling
  always_ff @(posedge clk_p or negedge sys_init_n) begin
    if (!sys_init_n) begin
      r_req       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 2'b11;
      r_adr_o     <= '0;
      r_dat_o     <= '0;
      r_address   <= '0;
      r_act       <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_startup   <= RST_ADR;
      r_start_cnt <= 2'd0;
      r_byte      <= 1'b0;
      r_op_dep    <= 1'b0;
      r_exam_last <= 1'b0;
      r_dep_last  <= 1'b0;
      r_tmo       <= '0;
    end else begin
      if (r_start_cnt != 2'd0) begin
        r_start_cnt <= r_start_cnt - 2'd1;
      end
      case (r_state)
        CS_IDLE: begin
          if (w_consume[KEY_START]) begin
            r_start_cnt <= 2'd2;
          end
          if (w_consume[KEY_EXAM] || w_consume[KEY_DEP]) begin
            r_req    <= 1'b1;
            r_byte   <= byte_mode;
            r_op_dep <= w_consume[KEY_DEP];
          end
        end
        CS_LOAD: begin
          r_address   <= switch_sr;
          r_act       <= 1'b1;
          r_exam_last <= 1'b0;
          r_dep_last  <= 1'b0;
          r_err       <= 1'b0;
        end
        CS_START: begin
          r_startup <= r_address[15:0];
        end
        CS_REQ: begin
          if (cpu_run) begin
            r_req <= 1'b0;
          end else if (dma_gnt) begin
            r_address   <= w_xfer_adr;
            r_exam_last <= ~r_op_dep;
            r_dep_last  <= r_op_dep;
            r_stb       <= 1'b1;
            r_we        <= r_op_dep;
            r_tmo       <= '0;
            if (r_byte) begin
              r_adr_o <= w_xfer_adr;
              r_sel   <= byte_sel(w_xfer_adr[0]);
              r_dat_o <= {switch_sr[HW-1:0], switch_sr[HW-1:0]};
            end else begin
              r_adr_o <= {w_xfer_adr[AW-1:1], 1'b0};
              r_sel   <= 2'b11;
              r_dat_o <= switch_sr[DW-1:0];
            end
          end
        end
        CS_XFER: begin
          if (dma_ack_i) begin
            if (r_op_dep) begin
              r_data <= r_byte ? {{HW{1'b0}}, r_dat_o[HW-1:0]} : r_dat_o;
            end else begin
              r_data <= r_byte ? {{HW{1'b0}}, w_rd_lane} : dma_dat_i;
            end
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_req <= 1'b0;
          end else if (r_tmo == TMO_LAST) begin
            r_err       <= 1'b1;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_req       <= 1'b0;
            r_exam_last <= 1'b0;
            r_dep_last  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        default: ;
      endcase
      // A running CPU owns the panel: drop display and step history
      if (cpu_run) begin
        r_act       <= 1'b0;
        r_exam_last <= 1'b0;
        r_dep_last  <= 1'b0;
      end
    end
  end

  assign dma_req     = r_req;
  assign dma_stb_o   = r_stb;
  assign dma_we_o    = r_we;
  assign dma_sel_o   = r_sel;
  assign dma_adr_o   = r_adr_o;
  assign dma_dat_o   = r_dat_o;
  assign address_reg = r_address;
  assign address_act = r_act;
  assign data_reg    = r_data;
  assign addr_err    = r_err;
  assign startup_adr = r_startup;
  assign cons_start  = (r_start_cnt != 2'd0);

endmodule
